fetch_stage: RTL and testbench

//  PC generator and instruction-fetch sequencer; sits directly upstream of the IF/ID pipeline registers.
//  - Drives InstrF/PCF/PCPlus4F into them.
//  - Runs a single-outstanding req/gnt/rvalid handshake to a variable-latency instruction memory.
//  - Honours decode stall, and EX-stage redirects for taken branch/jal/jalr.
//  - Sends a bubble (NOP) downstream whenever no instruction is ready.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 32 +++
 rtl/Register.sv | 24 ++
 rtl/next_pc_mux.sv | 33 +++
 rtl/fetch_stage.sv | 189 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 6 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width, the bubble instruction,
// the fetch sequencer state encoding and small PC helpers.
package pipeline_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    // addi x0,x0,0
    localparam word_t NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_REQ,
        FS_WAIT,
        FS_HOLD
    } fetchState_t;

    // Sequential successor; wraps modulo 2^32.
    function automatic word_t pcPlus4(input word_t pc);
        return pc + 32'd4;
    endfunction

    // Jump targets keep bit1 as given; bit0 is always cleared.
    function automatic word_t alignTarget(input word_t target);
        return {target[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus.
//   req    : fetch request (master -> slave)
//   addr   : request address (master -> slave)
//   gnt    : request accepted this cycle (slave -> master)
//   rvalid : response valid (slave -> master)
//   rdata  : response instruction (slave -> master)
interface fetch_stage_if;
    import pipeline_pkg::*;

    logic  req;
    word_t addr;
    logic  gnt;
    logic  rvalid;
    word_t rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/Register.sv
// Generic storage element with load enable.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   en       : load d on the next rising edge
//   d / q    : data in / registered data out (RESET_VAL under reset)
module Register #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/next_pc_mux.sv
// Next-PC selection for the fetch stage.
//   redirect : EX-stage taken branch/jump; highest priority
//   target   : redirect target (bit0 cleared here)
//   advance  : current instruction is leaving fetch; step sequentially
//   seqBase  : PC of the instruction that is leaving
//   curPc    : present PC, kept when nothing happens
//   nextPc   : value to load into the PC register
//   pcEn     : PC register load enable
module next_pc_mux
    import pipeline_pkg::*;
(
    input  logic  redirect,
    input  word_t target,
    input  logic  advance,
    input  word_t seqBase,
    input  word_t curPc,
    output word_t nextPc,
    output logic  pcEn
);

    always_comb begin
        nextPc = curPc;
        pcEn   = 1'b0;
        if (redirect) begin
            nextPc = alignTarget(target);
            pcEn   = 1'b1;
        end else if (advance) begin
            nextPc = pcPlus4(seqBase);
            pcEn   = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// PC generator and single-outstanding instruction-fetch sequencer feeding
// the IF/ID registers.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   StallF     : decode not accepting; hold the current instruction
//   RedirectE  : taken branch/jump resolved in EX
//   PCTargetE  : redirect target (bit0 forced to 0)
//   imem       : req/gnt/rvalid instruction-memory bus (master side)
//   InstrF     : instruction to IF/ID, NOP_INSTR when ValidF=0
//   PCF        : PC of InstrF
//   PCPlus4F   : PCF+4 modulo 2^32
//   ValidF     : InstrF is a real instruction
//   FetchBusy  : no instruction ready (= !ValidF)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 StallF,
    input  logic                 RedirectE,
    input  logic [31:0]          PCTargetE,
    fetch_stage_if.master        imem,
    output logic [31:0]          InstrF,
    output logic [31:0]          PCF,
    output logic [31:0]          PCPlus4F,
    output logic                 ValidF,
    output logic                 FetchBusy
);
    import pipeline_pkg::word_t;
    import pipeline_pkg::fetchState_t;
    import pipeline_pkg::FS_REQ;
    import pipeline_pkg::FS_WAIT;
    import pipeline_pkg::FS_HOLD;
    import pipeline_pkg::pcPlus4;

    fetchState_t state;
    fetchState_t stateNext;

    word_t pc;
    word_t pcNext;
    logic  pcEn;

    word_t reqPc;
    word_t holdInstr;
    word_t holdPc;

    logic  drop;
    logic  dropNext;

    logic  granted;
    logic  respOk;
    logic  advance;
    word_t seqBase;

    // A request is accepted only while REQ is presented.
    assign granted = (state == FS_REQ) && imem.gnt;

    // A response is usable only if it is not stale and not overridden by
    // a redirect in the same cycle.
    assign respOk = (state == FS_WAIT) && imem.rvalid && !drop && !RedirectE;

    assign advance = !StallF && (respOk || (state == FS_HOLD));
    assign seqBase = (state == FS_HOLD) ? holdPc : reqPc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FS_REQ;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            FS_REQ: begin
                if (imem.gnt) begin
                    stateNext = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (imem.rvalid) begin
                    stateNext = (drop || !StallF) ? FS_REQ : FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (!StallF) begin
                    stateNext = FS_REQ;
                end
            end
            default: stateNext = FS_REQ;
        endcase
        // A grant accepted in the redirect cycle still owes a response,
        // so wait for it (and drop it) before fetching the target.
        if (RedirectE) begin
            stateNext = granted ? FS_WAIT : FS_REQ;
        end
    end

    // Drop flag. A redirect out of WAIT leaves the stale response in
    // flight while we return to REQ, so the flag is consumed by the next
    // rvalid in whichever state it arrives, not only in WAIT.
    always_comb begin
        dropNext = drop;
        if (RedirectE) begin
            dropNext = ((state == FS_WAIT) && !imem.rvalid) || granted
                     || (drop && !imem.rvalid);
        end else if (drop && imem.rvalid) begin
            dropNext = 1'b0;
        end
    end

    next_pc_mux pcMux (
        .redirect (RedirectE),
        .target   (PCTargetE),
        .advance  (advance),
        .seqBase  (seqBase),
        .curPc    (pc),
        .nextPc   (pcNext),
        .pcEn     (pcEn)
    );

    Register #(.WIDTH(32), .RESET_VAL(RESET_PC)) pcReg (
        .clk (clk),
        .rst (rst),
        .en  (pcEn),
        .d   (pcNext),
        .q   (pc)
    );

    Register #(.WIDTH(32), .RESET_VAL(RESET_PC)) reqPcReg (
        .clk (clk),
        .rst (rst),
        .en  (granted),
        .d   (pc),
        .q   (reqPc)
    );

    Register #(.WIDTH(32), .RESET_VAL(NOP_INSTR)) holdInstrReg (
        .clk (clk),
        .rst (rst),
        .en  (respOk),
        .d   (imem.rdata),
        .q   (holdInstr)
    );

    Register #(.WIDTH(32), .RESET_VAL(RESET_PC)) holdPcReg (
        .clk (clk),
        .rst (rst),
        .en  (respOk),
        .d   (reqPc),
        .q   (holdPc)
    );

    Register #(.WIDTH(1), .RESET_VAL(1'b0)) dropReg (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (dropNext),
        .q   (drop)
    );

    // Bus outputs; req is masked during reset so nothing is issued early.
    assign imem.req  = (state == FS_REQ) && !rst;
    assign imem.addr = pc;

    // Downstream outputs: combinational pass-through in the response
    // cycle, registered copy while held.
    always_comb begin
        ValidF = 1'b0;
        InstrF = NOP_INSTR;
        PCF    = pc;
        if (state == FS_HOLD) begin
            ValidF = 1'b1;
            InstrF = holdInstr;
            PCF    = holdPc;
        end else if (respOk) begin
            ValidF = 1'b1;
            InstrF = imem.rdata;
            PCF    = reqPc;
        end
    end

    assign PCPlus4F  = pcPlus4(PCF);
    assign FetchBusy = !ValidF;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallF = 1'b0;
    logic        RedirectE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        ValidF;
    logic        FetchBusy;

    fetch_stage_if imem ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .StallF    (StallF),
        .RedirectE (RedirectE),
        .PCTargetE (PCTargetE),
        .imem      (imem),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .PCPlus4F  (PCPlus4F),
        .ValidF    (ValidF),
        .FetchBusy (FetchBusy)
    );

    always #5 clk = ~clk;

    // Memory model: one request at a time, response lat cycles after the
    // grant edge, contents = 0xA000_0000 ^ address. A manual override
    // injects an rvalid with nothing outstanding.
    int unsigned lat = 1;
    logic        gntEn = 1'b1;
    logic        manual = 1'b0;
    logic        manRvalid = 1'b0;
    logic        pend;
    int unsigned cnt;
    logic [31:0] pAddr;

    assign imem.gnt    = imem.req && gntEn && !pend;
    assign imem.rvalid = manual ? manRvalid : (pend && (cnt == 0));
    assign imem.rdata  = 32'hA000_0000 ^ pAddr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= 1'b0;
            cnt   <= 0;
            pAddr <= '0;
        end else if (imem.gnt) begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            pAddr <= imem.addr;
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_valid", {31'b0, ValidF}, 32'd0);
        chk("rst_instr", InstrF, 32'h0000_0013);
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_pcp4", PCPlus4F, 32'h4);
        chk("rst_req", {31'b0, imem.req}, 32'd0);
        chk("rst_busy", {31'b0, FetchBusy}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // 1: sequential fetch, 1-cycle memory
        chk("t1_req0", {31'b0, imem.req}, 32'd1);
        chk("t1_addr0", imem.addr, 32'h0);
        chk("t1_inv0", {31'b0, ValidF}, 32'd0);
        cyc; #1;
        chk("t1_val0", {31'b0, ValidF}, 32'd1);
        chk("t1_instr0", InstrF, 32'hA000_0000);
        chk("t1_pc0", PCF, 32'h0);
        chk("t1_pcp40", PCPlus4F, 32'h4);
        chk("t1_busy0", {31'b0, FetchBusy}, 32'd0);
        cyc; #1;
        chk("t1_addr4", imem.addr, 32'h4);
        chk("t1_inv4", {31'b0, ValidF}, 32'd0);
        chk("t1_nop4", InstrF, 32'h0000_0013);
        cyc; #1;
        chk("t1_val4", {31'b0, ValidF}, 32'd1);
        chk("t1_instr4", InstrF, 32'hA000_0004);
        chk("t1_pc4", PCF, 32'h4);
        cyc; #1;
        chk("t1_addr8", imem.addr, 32'h8);
        chk("t1_inv8", {31'b0, ValidF}, 32'd0);
        cyc; #1;
        chk("t1_val8", {31'b0, ValidF}, 32'd1);
        chk("t1_instr8", InstrF, 32'hA000_0008);
        chk("t1_pc8", PCF, 32'h8);

        // 2: latency 3, decode stall holds the instruction
        cyc; lat = 3; #1;
        chk("t2_addrC", imem.addr, 32'hC);
        chk("t2_reqC", {31'b0, imem.req}, 32'd1);
        cyc; #1;
        chk("t2_wait_req", {31'b0, imem.req}, 32'd0);
        chk("t2_wait_inv1", {31'b0, ValidF}, 32'd0);
        cyc; #1;
        chk("t2_wait_busy", {31'b0, FetchBusy}, 32'd1);
        cyc; StallF = 1'b1; #1;
        chk("t2_val", {31'b0, ValidF}, 32'd1);
        chk("t2_instr", InstrF, 32'hA000_000C);
        chk("t2_pc", PCF, 32'hC);
        for (int i = 0; i < 3; i++) begin
            cyc; #1;
            chk("t2_hold_val", {31'b0, ValidF}, 32'd1);
            chk("t2_hold_instr", InstrF, 32'hA000_000C);
            chk("t2_hold_pc", PCF, 32'hC);
            chk("t2_hold_req", {31'b0, imem.req}, 32'd0);
        end
        cyc; StallF = 1'b0; #1;
        chk("t2_rel_val", {31'b0, ValidF}, 32'd1);
        chk("t2_rel_pc", PCF, 32'hC);
        chk("t2_rel_pcp4", PCPlus4F, 32'h10);
        cyc; #1;
        chk("t2_next_req", {31'b0, imem.req}, 32'd1);
        chk("t2_next_addr", imem.addr, 32'h10);

        // 3: redirect while a fetch is outstanding
        cyc; RedirectE = 1'b1; PCTargetE = 32'h0000_0101; #1;
        chk("t3_wait_inv", {31'b0, ValidF}, 32'd0);
        cyc; RedirectE = 1'b0; lat = 1; #1;
        chk("t3_req", {31'b0, imem.req}, 32'd1);
        chk("t3_addr", imem.addr, 32'h100);
        chk("t3_inv_a", {31'b0, ValidF}, 32'd0);
        cyc; #1;
        chk("t3_stale_inv", {31'b0, ValidF}, 32'd0);
        chk("t3_addr_stable", imem.addr, 32'h100);
        cyc; #1;
        chk("t3_addr_gnt", imem.addr, 32'h100);
        cyc; #1;
        chk("t3_val", {31'b0, ValidF}, 32'd1);
        chk("t3_instr", InstrF, 32'hA000_0100);
        chk("t3_pc", PCF, 32'h100);

        // 4: redirect in the same cycle as a grant
        cyc; RedirectE = 1'b1; PCTargetE = 32'h0000_0200; #1;
        chk("t4_addr", imem.addr, 32'h104);
        chk("t4_req", {31'b0, imem.req}, 32'd1);
        cyc; RedirectE = 1'b0; #1;
        chk("t4_drop_inv", {31'b0, ValidF}, 32'd0);
        chk("t4_drop_nop", InstrF, 32'h0000_0013);
        cyc; #1;
        chk("t4_tgt_addr", imem.addr, 32'h200);
        chk("t4_tgt_req", {31'b0, imem.req}, 32'd1);
        cyc; #1;
        chk("t4_val", {31'b0, ValidF}, 32'd1);
        chk("t4_pc", PCF, 32'h200);
        chk("t4_instr", InstrF, 32'hA000_0200);

        // 5: top-of-address-space wrap, odd target
        cyc; gntEn = 1'b0; RedirectE = 1'b1; PCTargetE = 32'hFFFF_FFFD; #1;
        chk("t5_req", {31'b0, imem.req}, 32'd1);
        cyc; gntEn = 1'b1; RedirectE = 1'b0; #1;
        chk("t5_addr", imem.addr, 32'hFFFF_FFFC);
        cyc; #1;
        chk("t5_val", {31'b0, ValidF}, 32'd1);
        chk("t5_pc", PCF, 32'hFFFF_FFFC);
        chk("t5_pcp4", PCPlus4F, 32'h0);
        chk("t5_instr", InstrF, 32'h5FFF_FFFC);
        cyc; lat = 3; #1;
        chk("t5_wrap_addr", imem.addr, 32'h0);
        chk("t5_wrap_req", {31'b0, imem.req}, 32'd1);

        // 6: asynchronous reset in WAIT, stale rvalid after release
        cyc; #1;
        cyc; #1;
        cyc; #1;
        chk("t6_val0", {31'b0, ValidF}, 32'd1);
        chk("t6_instr0", InstrF, 32'hA000_0000);
        cyc; #1;
        chk("t6_addr4", imem.addr, 32'h4);
        cyc; #1;
        chk("t6_wait_req", {31'b0, imem.req}, 32'd0);
        chk("t6_wait_pcf", PCF, 32'h4);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_addr", imem.addr, 32'h0);
        chk("t6_rst_valid", {31'b0, ValidF}, 32'd0);
        chk("t6_rst_instr", InstrF, 32'h0000_0013);
        chk("t6_rst_pcf", PCF, 32'h0);
        chk("t6_rst_pcp4", PCPlus4F, 32'h4);
        chk("t6_rst_req", {31'b0, imem.req}, 32'd0);
        cyc;
        rst = 1'b0; manual = 1'b1; manRvalid = 1'b1; gntEn = 1'b0; #1;
        chk("t6_late_inv", {31'b0, ValidF}, 32'd0);
        chk("t6_late_nop", InstrF, 32'h0000_0013);
        chk("t6_late_req", {31'b0, imem.req}, 32'd1);
        chk("t6_late_addr", imem.addr, 32'h0);
        cyc; manual = 1'b0; manRvalid = 1'b0; gntEn = 1'b1; lat = 1; #1;
        chk("t6_first_addr", imem.addr, 32'h0);
        chk("t6_first_inv", {31'b0, ValidF}, 32'd0);
        cyc; #1;
        chk("t6_first_val", {31'b0, ValidF}, 32'd1);
        chk("t6_first_pc", PCF, 32'h0);
        chk("t6_first_instr", InstrF, 32'hA000_0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
